regfile_onehot: RTL
===================

# regfile_onehot

Thirty-two-entry, 32-bit MIPS general-purpose register file addressed entirely by one-hot selects. It sits directly downstream of the 5-to-32 register decoder: the controller decodes rs, rt and rd into `Aselect`, `Bselect` and `Dselect`, and this block drives the operand buses `abus`/`bbus` and accepts write-back on `dbus`. Register 0 is hardwired to zero. Malformed (multi-hot) selects are detected and flagged.

## Interface
- `WIDTH`, 32, data width of each register and bus
- `NREGS`, 32, number of registers; equals select-vector width

- `clk`  input  1  single system clock; all state updates on rising edge
- `rst_n`  input  1  synchronous, active-low reset, sampled on rising `clk`
- `Aselect`  input  NREGS  one-hot read select, port A (decoded rs)
- `Bselect`  input  NREGS  one-hot read select, port B (decoded rt)
- `Dselect`  input  NREGS  one-hot write select (decoded rd); all-zero means no write
- `dbus`  input  WIDTH  write-back data
- `abus`  output  WIDTH  port A read data
- `bbus`  output  WIDTH  port B read data
- `sel_err`  output  1  sticky: a multi-hot select was seen on any port
- `err_port`  output  3  sticky per-port error bits {D,B,A}

## Operation
- Storage: `NREGS` × `WIDTH` flops; entry 0 has no storage and always reads 0.
- Write: on rising `clk` with `rst_n`=1, if `Dselect` has exactly one bit set at index i≠0, reg[i] ← `dbus`. `Dselect`=0 or `Dselect`=bit 0: no write. Multi-hot `Dselect`: no register changes, error recorded.
- Read (combinational): `abus` = reg[i] where `Aselect` is one-hot at i; same for `bbus`/`Bselect`. All-zero select → bus = 0. Multi-hot select → bus = 0 and error recorded.
- Write-through bypass: if a read select is one-hot, equals a valid one-hot `Dselect` at i≠0, and `rst_n`=1, that read bus returns `dbus` in the same cycle (no stale value during write-back).
- Error capture: on each rising edge with `rst_n`=1, `err_port[k]` ← `err_port[k]` | multihot(select_k); `sel_err` = OR of `err_port`. Cleared only by reset.
- Both read ports may select the same register; both return the same value.

## Timing
- Write latency: data visible through normal read path in the cycle after the write edge; visible via bypass in the write cycle itself.
- Read latency: zero cycles (combinational from selects and state).
- Reset: while `rst_n`=0 at a rising edge, all registers ← 0, `err_port` ← 0, writes suppressed. While `rst_n`=0, `abus`/`bbus` are forced to 0 and bypass is disabled. Outputs after reset: `abus`=0, `bbus`=0, `sel_err`=0, `err_port`=3'b000.
- Reset asserted in the same cycle as a write: reset wins, register remains 0.
- Error flags update one edge after a multi-hot select is presented; bus zeroing on multi-hot is immediate.

## Structure
- Shared package `regfile_pkg`: `WIDTH`, `NREGS`, `ZERO_REG`=0, port-index constants `PORT_A`=0, `PORT_B`=1, `PORT_D`=2.
- One sub-module `onehot_check` (combinational, parameter N): outputs `is_zero`, `is_onehot`, `is_multihot`; instantiated three times, once per select.
- Read muxes are implemented as AND-OR over the select vector, without a re-encode to binary.

## Test plan
- Reset: hold `rst_n`=0 two cycles with `Dselect`=1<<5, `dbus`=32'hFFFF_FFFF → after release, `Aselect`=1<<5 reads 0; `sel_err`=0.
- Basic write/read: write 32'hDEAD_BEEF to reg 7, next cycle `Aselect`=`Bselect`=1<<7 → both buses 32'hDEAD_BEEF.
- Zero register: write 32'h1234_5678 with `Dselect`=1<<0 → `abus` with `Aselect`=1<<0 reads 0.
- Bypass: `Dselect`=`Aselect`=1<<3 with `dbus`=32'hA5A5_A5A5 in the same cycle, reg 3 previously 0 → `abus`=32'hA5A5_A5A5 in that cycle.
- Multi-hot: `Dselect`=(1<<2)|(1<<9) with `dbus`=32'h1 → regs 2 and 9 unchanged; next edge `err_port`=3'b100 and `sel_err`=1. `Aselect`=(1<<1)|(1<<4) → `abus`=0 immediately, `err_port[0]` set next edge.
- Sweep: write value i+100 to each reg 1..31, then read all pairs via A/B → each reads i+100; no error flags set.

Source files
------------

// File: rtl/regfile_onehot_pkg.sv
// rtl/regfile_onehot_pkg.sv - shared widths and port indices for the one-hot register file
package regfile_pkg;

    localparam int WIDTH    = 32;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 0;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;
    localparam int PORT_D = 2;

endpackage

// File: rtl/regfile_onehot_if.sv
// rtl/regfile_onehot_if.sv - select/data bundle between decoder-side controller and register file
interface regfile_onehot_if;
    import regfile_pkg::*;

    logic [NREGS-1:0] Aselect;
    logic [NREGS-1:0] Bselect;
    logic [NREGS-1:0] Dselect;
    logic [WIDTH-1:0] dbus;
    logic [WIDTH-1:0] abus;
    logic [WIDTH-1:0] bbus;
    logic             sel_err;
    logic [2:0]       err_port;

    modport master (
        output Aselect, Bselect, Dselect, dbus,
        input  abus, bbus, sel_err, err_port
    );

    modport slave (
        input  Aselect, Bselect, Dselect, dbus,
        output abus, bbus, sel_err, err_port
    );

endinterface

// File: rtl/regfile_onehot_check.sv
// rtl/regfile_onehot_check.sv - classifies a select vector as empty, one-hot or multi-hot
module onehot_check #(
    parameter int N = 32
) (
    input  logic [N-1:0] sel,
    output logic         is_zero,
    output logic         is_onehot,
    output logic         is_multihot
);

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
    logic [N-1:0] low_cleared;

    always_comb begin
        low_cleared = sel & (sel - N'(1));
        is_zero     = (sel == '0);
        is_onehot   = !is_zero && (low_cleared == '0);
        is_multihot = (low_cleared != '0);
    end

endmodule

// File: rtl/regfile_onehot.sv
// rtl/regfile_onehot.sv - 32x32 register file with one-hot selects, write bypass and select error capture
module regfile_onehot
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    regfile_onehot_if.slave   rf
);

    logic [WIDTH-1:0] regs [1:NREGS-1];
    logic [2:0]       err_q;

    logic a_zero, a_onehot, a_multi;
    logic b_zero, b_onehot, b_multi;
    logic d_zero, d_onehot, d_multi;

    onehot_check #(.N(NREGS)) u_chk_a (
        .sel(rf.Aselect), .is_zero(a_zero), .is_onehot(a_onehot), .is_multihot(a_multi)
    );
    onehot_check #(.N(NREGS)) u_chk_b (
        .sel(rf.Bselect), .is_zero(b_zero), .is_onehot(b_onehot), .is_multihot(b_multi)
    );
    onehot_check #(.N(NREGS)) u_chk_d (
        .sel(rf.Dselect), .is_zero(d_zero), .is_onehot(d_onehot), .is_multihot(d_multi)
    );

    logic d_write;
    logic a_bypass, b_bypass;
    logic [WIDTH-1:0] a_raw, b_raw;
    logic [2:0] multi_vec;

    always_comb begin
        d_write  = rst_n && d_onehot && !d_zero && !rf.Dselect[ZERO_REG];
        a_bypass = d_write && a_onehot && (rf.Aselect == rf.Dselect);
        b_bypass = d_write && b_onehot && (rf.Bselect == rf.Dselect);

        multi_vec         = '0;
        multi_vec[PORT_A] = a_multi;
        multi_vec[PORT_B] = b_multi;
        multi_vec[PORT_D] = d_multi;
    end

    // AND-OR read mux; entry 0 has no storage so it contributes nothing.
    always_comb begin
        a_raw = '0;
        b_raw = '0;
        for (int i = 1; i < NREGS; i++) begin
            a_raw = a_raw | (regs[i] & {WIDTH{rf.Aselect[i]}});
            b_raw = b_raw | (regs[i] & {WIDTH{rf.Bselect[i]}});
        end
    end

    always_comb begin
        if (!rst_n || a_zero || a_multi) begin
            rf.abus = '0;
        end else if (a_bypass) begin
            rf.abus = rf.dbus;
        end else begin
            rf.abus = a_raw;
        end

        if (!rst_n || b_zero || b_multi) begin
            rf.bbus = '0;
        end else if (b_bypass) begin
            rf.bbus = rf.dbus;
        end else begin
            rf.bbus = b_raw;
        end

        rf.err_port = err_q;
        rf.sel_err  = |err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (d_write && rf.Dselect[i]) begin
                    regs[i] <= rf.dbus;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | multi_vec;
        end
    end

endmodule
